// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and the OAM DMA state encoding.
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] DMA_IDLE_ADDR = 16'hFFFF;
    localparam logic [7:0]  ECHO_PAGE_LO  = 8'hE0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RD,
        WAIT,
        LATCH,
        WR
    } dma_state_t;

    // Echo RAM (0xE000-0xFFFF pages) mirrors WRAM 0x2000 lower.
    function automatic logic [7:0] dma_src_page(input logic [7:0] page);
        return (page >= ECHO_PAGE_LO) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_engine_if.sv
// Byte-wide memory-map bus: one side drives address/data/strobe, the other returns read data.
interface oam_dma_engine_if;

    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );

endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a CPU write to 0xFF46 copies OAM_LEN bytes from page<<8 into OAM.
// The bus outputs are decoded from the state register so an asynchronous reset
// returns the DMA port to the idle address within the same cycle.
module oam_dma_engine
    import gb_mem_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int OAM_LEN = 160
) (
    input  logic              clk,
    input  logic              rst,
    oam_dma_engine_if.slave   mmio_if,
    oam_dma_engine_if.master  dma_req,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);
    localparam logic [1:0] WAIT_INI = 2'(RD_LAT - 1);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic [7:0]  page_reg;
    logic [7:0]  idx;
    logic [7:0]  data_lat;
    logic [1:0]  wait_cnt;
    logic [1:0]  wait_dec;
    logic        sel_wr;
    logic        sel_wr_d;
    logic        start_evt;
    logic [15:0] src_addr;

    assign sel_wr    = (mmio_if.addr_select == DMA_REG_ADDR) && mmio_if.write_enable;
    assign start_evt = sel_wr && !sel_wr_d;
    assign wait_dec  = wait_cnt - 2'd1;
    assign src_addr  = {dma_src_page(page_reg), idx};
    assign busy      = (state != IDLE);

    // Register readback; anything other than 0xFF46 reads as open bus.
    always_comb begin
        mmio_if.read_out = 8'hFF;
        if (mmio_if.addr_select == DMA_REG_ADDR)
            mmio_if.read_out = page_reg;
    end

    // Next-state decode; a start event restarts from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            START:   state_nxt = RD;
            RD:      state_nxt = (RD_LAT == 1) ? LATCH : WAIT;
            WAIT:    state_nxt = (wait_dec == 2'd0) ? LATCH : WAIT;
            LATCH:   state_nxt = WR;
            WR:      state_nxt = (idx == LAST_IDX) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
        if (start_evt)
            state_nxt = START;
    end

    // DMA bus drive: source address while reading, OAM slot during the single write cycle.
    always_comb begin
        dma_req.addr_select  = DMA_IDLE_ADDR;
        dma_req.write_value  = 8'h00;
        dma_req.write_enable = 1'b0;
        case (state)
            RD, WAIT, LATCH: dma_req.addr_select = src_addr;
            WR: begin
                dma_req.addr_select  = OAM_BASE + {8'h00, idx};
                dma_req.write_value  = data_lat;
                dma_req.write_enable = 1'b1;
            end
            default: dma_req.addr_select = DMA_IDLE_ADDR;
        endcase
    end

    // State, page register, byte index, read-wait counter, data latch and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            page_reg <= 8'h00;
            idx      <= 8'h00;
            data_lat <= 8'h00;
            wait_cnt <= 2'd0;
            sel_wr_d <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel_wr_d <= sel_wr;
            done     <= 1'b0;
            if (start_evt) begin
                // Restart drops the byte in flight; a final WR in this cycle gets no done.
                page_reg <= mmio_if.write_value;
                idx      <= 8'h00;
            end else begin
                case (state)
                    START: idx <= 8'h00;
                    RD:    wait_cnt <= WAIT_INI;
                    WAIT:  wait_cnt <= wait_dec;
                    LATCH: data_lat <= dma_req.read_out;
                    WR: begin
                        if (idx == LAST_IDX)
                            done <= 1'b1;
                        else
                            idx <= idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
